// File: rtl/hyper_rx_fifo.sv
// ============================================================================
// Module      : hyper_rx_fifo
// Description : HyperBus PHY receive FIFO, first-word-fall-through upstream,
//               almost-full warning and sticky overflow on dropped words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyper_rx_fifo #(
    parameter int FIFO_SIZE       = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int AFULL_THRESHOLD = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         valid_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         almost_full_o,
    output logic [$clog2(FIFO_SIZE):0]   fill_o,
    output logic                         overflow_o
);

    localparam int c_ptr_w = $clog2(FIFO_SIZE);
    localparam int c_cnt_w = c_ptr_w + 1;

    if ((FIFO_SIZE < 2) || ((FIFO_SIZE & (FIFO_SIZE - 1)) != 0)) begin : g_bad_size
        $error("hyper_rx_fifo: FIFO_SIZE must be a power of two >= 2");
    end
    if ((AFULL_THRESHOLD < 1) || (AFULL_THRESHOLD > FIFO_SIZE)) begin : g_bad_afull
        $error("hyper_rx_fifo: AFULL_THRESHOLD must be in 1..FIFO_SIZE");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_SIZE];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_SIZE];
    logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]    count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic w_pop;
    logic w_push;
    logic w_full;

    assign w_full = (count_q == c_cnt_w'(FIFO_SIZE));
    assign w_pop  = (count_q != '0) && ready_i;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push = valid_i && (!w_full || w_pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                count_d = count_q - c_cnt_w'(1);
            end
            if (valid_i && !w_push) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_SIZE; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_SIZE; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign data_o        = mem_q[rd_ptr_q];
    assign valid_o       = (count_q != '0);
    assign fill_o        = count_q;
    assign almost_full_o = (count_q >= c_cnt_w'(AFULL_THRESHOLD));
    assign overflow_o    = overflow_q;

endmodule

`default_nettype wire

// File: doc/hyper_rx_fifo.md
Name: hyper_rx_fifo

Overview:
Receive-side buffer between the HyperBus PHY read path and the AXI read-data channel. It accepts one DATA_WIDTH word per valid_i strobe from the PHY, with no backpressure, and presents a first-word-fall-through valid/ready stream upstream. It raises almost_full_o so the transaction controller can end the burst (deassert CS) before words are lost. Lost words are flagged by a sticky overflow_o.

Parameters:
FIFO_SIZE, 8, number of entries; power of two, >= 2
DATA_WIDTH, 16, word width in bits
AFULL_THRESHOLD, 6, fill level at and above which almost_full_o asserts; range 1..FIFO_SIZE

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous flush: empties FIFO and clears overflow
data_i  input  DATA_WIDTH  word from PHY
valid_i  input  1  data_i strobe; no ready returned to the PHY
data_o  output  DATA_WIDTH  head-of-queue word
valid_o  output  1  FIFO non-empty
ready_i  input  1  upstream accepts data_o
almost_full_o  output  1  fill >= AFULL_THRESHOLD
fill_o  output  $clog2(FIFO_SIZE)+1  current occupancy, 0..FIFO_SIZE
overflow_o  output  1  sticky: a word was dropped

Behaviour:
- Reset (rst_ni low, asynchronous):
  - read/write pointers = 0, count = 0, storage = all zeros.
  - Outputs: valid_o = 0, data_o = 0, almost_full_o = 0, fill_o = 0, overflow_o = 0.
- State:
  - write ptr and read ptr, each $clog2(FIFO_SIZE) bits; both wrap naturally modulo FIFO_SIZE.
  - count register, $clog2(FIFO_SIZE)+1 bits.
- Pop: valid_o && ready_i.
  - Read ptr advances by 1.
  - The entry is not cleared.
- Push: valid_i && (count < FIFO_SIZE || pop).
  - data_i is stored at the write ptr; write ptr advances by 1.
  - When full, a push in the same cycle as a pop is accepted.
- Drop: valid_i && count == FIFO_SIZE && !pop.
  - The word is discarded; pointers and count are unchanged.
  - overflow_o is set on the next edge.
- Count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
  - count never exceeds FIFO_SIZE and never underflows.
- Output timing:
  - valid_o = (count != 0).
  - data_o = storage[read ptr], combinational from registers.
  - fill_o = count.
  - almost_full_o = (count >= AFULL_THRESHOLD), combinational from registered count.
- Latency:
  - A word pushed at edge N appears on data_o with valid_o=1 after edge N; no bypass of an empty FIFO in the same cycle.
  - Pop at edge N exposes the next entry after edge N.
- Empty with simultaneous push and ready_i:
  - No pop occurs, because valid_o = 0.
  - The word is stored; count becomes 1.
- clear_i (synchronous):
  - Sets pointers = 0, count = 0, overflow_o = 0.
  - Has priority over a push or pop in the same cycle; that push is discarded without setting overflow.
  - Storage contents need not be cleared.
- overflow_o:
  - Once set, remains 1 until clear_i or reset.
  - Is not cleared by pops.
- Upstream must hold data_o stable while valid_o && !ready_i; this is guaranteed because the head entry is only overwritten after it is popped.
- Parameter constraints: FIFO_SIZE that is not a power of two, or AFULL_THRESHOLD outside 1..FIFO_SIZE, is rejected with an elaboration-time assertion.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles with ready_i=0 -> fill_o 1,2,3; valid_o=1 one edge after the first push; data_o=0x1111.
- Fill to 8 with ready_i=0 -> almost_full_o=1 from fill 6; 9th push drops the word, overflow_o=1, fill_o stays 8; the 8 words read back in order, then valid_o=0.
- Full FIFO, push 0xAAAA with ready_i=1 in the same cycle -> accepted, fill_o stays 8, overflow_o=0; 0xAAAA is the last word read.
- Continuous push and pop over 20 words, ready_i=1 -> in-order delivery across pointer wrap, fill_o oscillates 0..1, no overflow.
- Overflowed FIFO with 5 entries, assert clear_i together with valid_i -> next cycle fill_o=0, valid_o=0, overflow_o=0, pushed word absent.
- Assert rst_ni low mid-stream (fill 4, overflow 1), asynchronously between edges -> all outputs 0 immediately, before the next clock edge.
